// File: rtl/iot_byte_feeder_if.sv
// Word-in / byte-out bundle between an upstream word source, the byte feeder
// and the IOTDF byte input.
interface iot_byte_feeder_if;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;

  modport master (output s_valid, s_data, busy, input s_ready, in_en, iot_in);
  modport slave  (input s_valid, s_data, busy, output s_ready, in_en, iot_in);
endinterface

// File: rtl/iot_byte_feeder.sv
// Buffers 128-bit words in a small FIFO and streams them MSB byte first onto
// the IOTDF byte input, stalling while IOTDF reports busy.
module iot_byte_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  iot_byte_feeder_if.slave  bus,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              idle
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [127:0]     mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic [3:0]       j_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  logic             in_en_reg;
  logic [7:0]       iot_in_reg;

  logic         full, empty, push, issue, pop;
  logic [127:0] head_word;
  logic [7:0]   head_bytes [16];

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign push  = bus.s_valid && !full;
  assign issue = !bus.busy && !empty;
  // The head leaves the FIFO on the same edge its last byte goes out, so j is
  // back at zero whenever the FIFO is empty.
  assign pop   = issue && (j_reg == 4'd15);

  assign head_word = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      assign head_bytes[gi] = head_word[127-8*gi -: 8];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi)))
          mem_reg[gi] <= bus.s_data;
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW+1)'(1);
    else if (pop && !push)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      j_reg        <= '0;
      word_cnt_reg <= '0;
      in_en_reg    <= 1'b0;
      iot_in_reg   <= 8'h00;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (issue) begin
        iot_in_reg <= head_bytes[j_reg];
        in_en_reg  <= 1'b1;
        j_reg      <= j_reg + 4'd1;
        if (pop)
          word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end else begin
        iot_in_reg <= 8'h00;
        in_en_reg  <= 1'b0;
      end
    end
  end

  assign bus.s_ready = !full;
  assign bus.in_en   = in_en_reg;
  assign bus.iot_in  = iot_in_reg;
  assign word_cnt    = word_cnt_reg;
  assign idle        = empty;
endmodule
